// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants: data width, reset PC, buffer depth
// and the instruction buffer entry.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int FETCH_DEPTH = 2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction memory request/response, decode handshake and
// core control (redirect, halt, idle status).
interface fetch_unit_if;
    import riscv_pkg::*;

    logic [XLEN-1:0] inst_addr;
    logic            inst_req;
    logic [XLEN-1:0] inst;

    logic            dec_valid;
    logic            dec_ready;
    logic [XLEN-1:0] dec_inst;
    logic [XLEN-1:0] dec_pc;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            halt_req;
    logic            fetch_idle;

    modport master (
        output inst_addr, inst_req, dec_valid, dec_inst, dec_pc, fetch_idle,
        input  inst, dec_ready, redirect_valid, redirect_pc, halt_req
    );

    modport slave (
        input  inst_addr, inst_req, dec_valid, dec_inst, dec_pc, fetch_idle,
        output inst, dec_ready, redirect_valid, redirect_pc, halt_req
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, inst} entries with flush; only pointers
// and count are reset, storage is left as-is.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic          empty,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, credit-limited requests to a fixed
// 1-cycle memory, epoch-tagged responses, redirect flush and sticky halt.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic clk,
    input  logic rst_b,
    fetch_unit_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [XLEN-1:0] pc_p0;
    logic            epoch_p0;
    logic            vld_p1;
    logic [XLEN-1:0] pc_p1;
    logic            epoch_p1;

    logic [CW-1:0]   count;
    logic [CW:0]     used;
    logic            credit_ok;
    logic            halted;
    logic            req;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    fetch_entry_t    head;
    fetch_entry_t    push_data;

    assign halted    = (state_q == ST_HALT);
    assign used      = {1'b0, count} + {{CW{1'b0}}, vld_p1};
    assign credit_ok = (used < (CW+1)'(DEPTH));

    // Occupancy counts the in-flight slot, so a pop never frees credit in the same cycle.
    assign req  = !rst_b && credit_ok && !halted && !bus.halt_req && !bus.redirect_valid;
    assign pop  = !rst_b && !fifo_empty && bus.dec_ready;
    assign push = vld_p1 && (epoch_p1 == epoch_p0) && !bus.redirect_valid;

    assign push_data.pc   = pc_p1;
    assign push_data.inst = bus.inst;

    always_comb begin
        state_d = state_q;
        if (bus.halt_req) state_d = ST_HALT;
    end

    always_ff @(posedge clk) begin
        if (rst_b) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    // Stage p0: PC and epoch, request issue.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            pc_p0    <= RESET_PC;
            epoch_p0 <= 1'b0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= req;
            if (bus.redirect_valid) begin
                pc_p0    <= word_align(bus.redirect_pc);
                epoch_p0 <= ~epoch_p0;
            end else if (req) begin
                pc_p0 <= pc_p0 + 32'd4;
            end
        end
    end

    // Stage p1: request in flight, memory data arrives this cycle.
    always_ff @(posedge clk) begin
        if (req) begin
            pc_p1    <= pc_p0;
            epoch_p1 <= epoch_p0;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst_b),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (bus.redirect_valid),
        .head      (head),
        .empty     (fifo_empty),
        .count     (count)
    );

    assign bus.inst_addr  = pc_p0;
    assign bus.inst_req   = req;
    assign bus.dec_valid  = !rst_b && !fifo_empty;
    assign bus.dec_inst   = rst_b ? '0 : head.inst;
    assign bus.dec_pc     = rst_b ? '0 : head.pc;
    assign bus.fetch_idle = !rst_b && halted && !vld_p1;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam int DEPTH = 2;
    localparam logic [31:0] MAIN_RESET = 32'h0000_0000;
    localparam logic [31:0] ALT_RESET  = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_b;
    logic rst2;
    fetch_unit_if bus();
    fetch_unit_if bus2();

    fetch_unit #(.RESET_PC(MAIN_RESET), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_b(rst_b), .bus(bus));
    fetch_unit #(.RESET_PC(ALT_RESET), .DEPTH(DEPTH)) dut2 (
        .clk(clk), .rst_b(rst2), .bus(bus2));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    // Reference model: buffered entries as a queue, one in-flight slot.
    logic [31:0]  salt = 32'h0;
    logic [31:0]  m_pc;
    fetch_entry_t m_q[$];
    bit           m_infl;
    logic [31:0]  m_infl_pc;
    bit           m_halted;
    bit           model_ok = 1'b0;
    logic         mem_req_d = 1'b0;
    logic [31:0]  mem_addr_d = 32'h0;

    initial begin
        forever begin
            bit exp_req;
            fetch_entry_t e;
            @(negedge clk);
            if (rst_b) begin
                chk1("rst_inst_req", bus.inst_req, 1'b0);
                chk1("rst_dec_valid", bus.dec_valid, 1'b0);
                chk1("rst_fetch_idle", bus.fetch_idle, 1'b0);
                chk("rst_dec_inst", bus.dec_inst, 32'h0);
                chk("rst_dec_pc", bus.dec_pc, 32'h0);
                m_pc = MAIN_RESET;
                m_q.delete();
                m_infl = 1'b0;
                m_halted = 1'b0;
                model_ok = 1'b1;
            end else if (model_ok) begin
                exp_req = ((m_q.size() + int'(m_infl)) < DEPTH) && !m_halted
                          && !bus.halt_req && !bus.redirect_valid;
                chk1("inst_req", bus.inst_req, exp_req);
                chk("inst_addr", bus.inst_addr, m_pc);
                chk1("dec_valid", bus.dec_valid, m_q.size() != 0);
                if (m_q.size() != 0) begin
                    chk("dec_pc", bus.dec_pc, m_q[0].pc);
                    chk("dec_inst", bus.dec_inst, m_q[0].inst);
                end
                chk1("fetch_idle", bus.fetch_idle, m_halted && !m_infl);
                if (m_q.size() != 0 && bus.dec_ready) void'(m_q.pop_front());
                if (m_infl && !bus.redirect_valid) begin
                    e.pc = m_infl_pc;
                    e.inst = m_infl_pc ^ salt;
                    m_q.push_back(e);
                end
                if (bus.redirect_valid) m_q.delete();
                m_infl = exp_req;
                m_infl_pc = m_pc;
                if (bus.redirect_valid) m_pc = {bus.redirect_pc[31:2], 2'b00};
                else if (exp_req) m_pc = m_pc + 32'd4;
                if (bus.halt_req) m_halted = 1'b1;
            end
            mem_req_d = bus.inst_req;
            mem_addr_d = bus.inst_addr;
        end
    end

    // Memory: word = address ^ salt, one cycle after an accepted request.
    initial begin
        bus.inst = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.inst = mem_req_d ? (mem_addr_d ^ salt) : $urandom();
        end
    end

    // Second instance: reset PC near the top of the address space.
    initial begin
        logic [31:0] seen[$];
        rst2 = 1'b1;
        bus2.inst = 32'h0;
        bus2.dec_ready = 1'b1;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc = 32'h0;
        bus2.halt_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #3;
            if (bus2.inst_req) seen.push_back(bus2.inst_addr);
            @(posedge clk);
            #1;
        end
        chk1("wrap_req_count", seen.size() >= 3, 1'b1);
        if (seen.size() >= 3) begin
            chk("wrap_req0", seen[0], 32'hFFFF_FFF8);
            chk("wrap_req1", seen[1], 32'hFFFF_FFFC);
            chk("wrap_req2", seen[2], 32'h0000_0000);
        end
    end

    initial begin
        int  nreq;
        bit  found;
        rst_b = 1'b1;
        bus.dec_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.halt_req = 1'b0;

        step();
        settle();
        chk("reset_pc", bus.inst_addr, 32'h0);

        // Streaming after reset release, word = address.
        step();
        rst_b = 1'b0;
        settle();
        chk1("s_req0", bus.inst_req, 1'b1);
        chk("s_addr0", bus.inst_addr, 32'h0);
        step();
        settle();
        chk("s_addr1", bus.inst_addr, 32'h4);
        chk1("s_dv1", bus.dec_valid, 1'b0);
        step();
        settle();
        chk1("s_dv2", bus.dec_valid, 1'b1);
        chk("s_pc2", bus.dec_pc, 32'h0);
        chk("s_inst2", bus.dec_inst, 32'h0);
        step();
        settle();
        chk("s_pc3", bus.dec_pc, 32'h4);
        chk("s_inst3", bus.dec_inst, 32'h4);

        // Backpressure: buffer fills to DEPTH and holds the oldest entry.
        step();
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        bus.dec_ready = 1'b0;
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            settle();
            if (bus.inst_req) nreq++;
            step();
        end
        settle();
        chk("bp_nreq", nreq, 32'd2);
        chk1("bp_req_low", bus.inst_req, 1'b0);
        chk("bp_pc_held", bus.dec_pc, 32'h0);
        step();
        bus.dec_ready = 1'b1;
        settle();
        chk("bp_drain0", bus.dec_pc, 32'h0);
        step();
        settle();
        chk("bp_drain1", bus.dec_pc, 32'h4);

        // Redirect with buffer holding 0x8 and 0xC in flight.
        step();
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (bus.dec_valid && bus.dec_pc == 32'h8) found = 1'b1;
        end
        chk1("rd_found8", found, 1'b1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h1003;
        settle();
        chk1("rd_req_low", bus.inst_req, 1'b0);
        step();
        bus.redirect_valid = 1'b0;
        settle();
        chk("rd_addr", bus.inst_addr, 32'h1000);
        chk1("rd_req", bus.inst_req, 1'b1);
        chk1("rd_flushed", bus.dec_valid, 1'b0);
        step();
        settle();
        chk1("rd_dropped", bus.dec_valid, 1'b0);
        step();
        settle();
        chk("rd_dec_pc", bus.dec_pc, 32'h1000);
        chk("rd_dec_inst", bus.dec_inst, 32'h1000);

        // Halt with a request in flight, then redirect while halted.
        step();
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        step();
        bus.halt_req = 1'b1;
        settle();
        chk1("h_req_low", bus.inst_req, 1'b0);
        step();
        bus.halt_req = 1'b0;
        bus.dec_ready = 1'b0;
        settle();
        chk1("h_req_low2", bus.inst_req, 1'b0);
        chk1("h_idle", bus.fetch_idle, 1'b1);
        chk("h_delivered", bus.dec_pc, 32'h0);
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h200;
        settle();
        step();
        bus.redirect_valid = 1'b0;
        settle();
        chk1("h_flushed", bus.dec_valid, 1'b0);
        chk1("h_no_restart", bus.inst_req, 1'b0);
        chk("h_pc", bus.inst_addr, 32'h200);
        step();
        settle();
        chk1("h_still_stopped", bus.inst_req, 1'b0);

        // One-cycle reset with a full buffer.
        step();
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        repeat (4) step();
        settle();
        chk1("rf_full", bus.dec_valid, 1'b1);
        step();
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        bus.dec_ready = 1'b1;
        settle();
        chk1("rf_empty", bus.dec_valid, 1'b0);
        chk1("rf_req", bus.inst_req, 1'b1);
        chk("rf_addr", bus.inst_addr, 32'h0);
        step();
        step();
        settle();
        chk("rf_first", bus.dec_pc, 32'h0);

        // Randomized traffic.
        step();
        rst_b = 1'b1;
        salt = 32'h5A5A_0000;
        step();
        rst_b = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step();
            rst_b = ($urandom_range(0, 99) == 0);
            bus.halt_req = ($urandom_range(0, 149) == 0);
            bus.dec_ready = ($urandom_range(0, 9) < 7);
            bus.redirect_valid = ($urandom_range(0, 15) == 0);
            bus.redirect_pc = $urandom();
        end
        step();
        rst_b = 1'b0;
        bus.halt_req = 1'b0;
        bus.redirect_valid = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
